// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared types, constants and tie-break helper for the cache memory arbiter
package cache_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} arb_state_t;
  localparam logic ARB_PORT_I = 1'b0;
  localparam logic ARB_PORT_D = 1'b1;
  localparam int PRIO_RR = 0;
  localparam int PRIO_FIXED = 1;
  function automatic logic arb_pick(input logic v0, input logic v1, input logic last, input logic fixed);
    return (v0 && v1) ? (fixed ? ARB_PORT_D : ~last) : (v1 ? ARB_PORT_D : ARB_PORT_I);
  endfunction
endpackage

// File: rtl/cache_arb_stats.sv
// cache_arb_stats: grant and wait counters for the cache memory arbiter, wrapping modulo 2^32
module cache_arb_stats
  import cache_arb_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  arb_state_t  state,
  input  logic        p0_valid,
  input  logic        p1_valid,
  input  logic        mem_ready,
  output logic [31:0] grant0,
  output logic [31:0] grant1,
  output logic [31:0] wait_cnt
);
  // count completions per port and cycles in which any requester is left waiting
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      grant0 <= '0;
      grant1 <= '0;
      wait_cnt <= '0;
    end else begin
      if (mem_ready && state == BUSY0) grant0 <= grant0 + 32'd1;
      if (mem_ready && state == BUSY1) grant1 <= grant1 + 32'd1;
      if ((p0_valid && state != BUSY0) || (p1_valid && state != BUSY1)) wait_cnt <= wait_cnt + 32'd1;
    end
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one memory port between icache (port 0) and dcache (port 1); stats under CACHE_ARB_STATS_EN
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] p0_addr_i,
  input  logic        p0_valid_i,
  output logic [31:0] p0_dout_o,
  output logic        p0_ready_o,
  input  logic [31:0] p1_addr_i,
  input  logic [31:0] p1_din_i,
  input  logic [3:0]  p1_wmask_i,
  input  logic        p1_valid_i,
  output logic [31:0] p1_dout_o,
  output logic        p1_ready_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_din_o,
  output logic [3:0]  mem_wmask_o,
  output logic        mem_valid_o,
  input  logic [31:0] mem_dout_i,
  input  logic        mem_ready_i,
  output logic [31:0] stat_grant0_o,
  output logic [31:0] stat_grant1_o,
  output logic [31:0] stat_wait_o
);
  arb_state_t state_q;
  logic last_q;
  logic win;
  logic g0;
  logic g1;
  assign win = arb_pick(p0_valid_i, p1_valid_i, last_q, PRIO_MODE == PRIO_FIXED);
  assign g0 = state_q == BUSY0;
  assign g1 = state_q == BUSY1;
  // grant in IDLE, hold until the memory completes, then always pass back through IDLE
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      last_q <= ARB_PORT_D;
    end else if (state_q == IDLE) begin
      if (p0_valid_i || p1_valid_i) state_q <= win ? BUSY1 : BUSY0;
    end else if (mem_ready_i) begin
      state_q <= IDLE;
      last_q <= g1 ? ARB_PORT_D : ARB_PORT_I;
    end
  assign mem_valid_o = g0 | g1;
  assign mem_addr_o = g0 ? p0_addr_i : g1 ? p1_addr_i : '0;
  assign mem_din_o = g1 ? p1_din_i : '0;
  assign mem_wmask_o = g1 ? p1_wmask_i : '0;
  assign p0_ready_o = g0 & mem_ready_i;
  assign p1_ready_o = g1 & mem_ready_i;
  assign p0_dout_o = g0 ? mem_dout_i : '0;
  assign p1_dout_o = g1 ? mem_dout_i : '0;
`ifdef CACHE_ARB_STATS_EN
  cache_arb_stats u_stats (
    .clk(clk),
    .resetn(resetn),
    .state(state_q),
    .p0_valid(p0_valid_i),
    .p1_valid(p1_valid_i),
    .mem_ready(mem_ready_i),
    .grant0(stat_grant0_o),
    .grant1(stat_grant1_o),
    .wait_cnt(stat_wait_o)
  );
`else
  assign stat_grant0_o = '0;
  assign stat_grant1_o = '0;
  assign stat_wait_o = '0;
`endif
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Two-port arbiter that shares the single memory port behind the cache block between the instruction-cache refill path (port 0) and the data-cache refill/write-through path (port 1). It replaces the pure `is_instruction` steering mux, so both caches can have requests pending at once. Each grant is held until the downstream `ready` completes the transaction, and fairness is enforced between the two ports. The arbiter sits between the icache/dcache `ram_*` ports and the SoC memory controller.

## Interface
- `PRIO_MODE`, default 0: 0 = round-robin; 1 = fixed priority, port 1 (dcache) wins ties.
- `clk`  in  1  single clock, all logic on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `p0_addr_i`  in  32  icache request address.
- `p0_valid_i`  in  1  icache request; held with `p0_addr_i` stable until `p0_ready_o`.
- `p0_dout_o`  out  32  read data to icache.
- `p0_ready_o`  out  1  one-cycle completion pulse to icache.
- `p1_addr_i`  in  32  dcache request address.
- `p1_din_i`  in  32  dcache write data.
- `p1_wmask_i`  in  4  dcache byte write mask; 0 = read.
- `p1_valid_i`  in  1  dcache request; held with `p1_addr_i`, `p1_din_i` and `p1_wmask_i` stable until `p1_ready_o`.
- `p1_dout_o`  out  32  read data to dcache.
- `p1_ready_o`  out  1  one-cycle completion pulse to dcache.
- `mem_addr_o`  out  32  downstream address.
- `mem_din_o`  out  32  downstream write data.
- `mem_wmask_o`  out  4  downstream write mask.
- `mem_valid_o`  out  1  downstream request.
- `mem_dout_i`  in  32  downstream read data.
- `mem_ready_i`  in  1  downstream completion; only sampled while `mem_valid_o` = 1.
- `stat_grant0_o`, `stat_grant1_o`, `stat_wait_o`  out  32 each  statistics counters; see Configuration.

## Operation
- States:
  - IDLE: no grant.
  - BUSY0: port 0 owns the memory port.
  - BUSY1: port 1 owns the memory port.
- Transitions:
  - IDLE → BUSYn on the next edge when any `pn_valid_i` = 1. The winner is chosen in IDLE.
  - BUSYn → IDLE on the edge where `mem_ready_i` = 1.
- Round-robin pointer `last_q` (reset 1, so port 0 wins the first tie):
  - Set to n on completion of BUSYn.
  - On a tie, the port ≠ `last_q` wins.
- PRIO_MODE=1: port 1 always wins a tie; `last_q` is ignored.
- In BUSYn:
  - `mem_addr_o`, `mem_din_o` and `mem_wmask_o` combinationally follow port n. Port 0 drives `din` = 0 and `wmask` = 0.
  - `mem_valid_o` = 1.
  - `pn_ready_o` = `mem_ready_i`.
  - `pn_dout_o` = `mem_dout_i`.
- Non-granted port: `ready` = 0, `dout` = 0.
- In IDLE, all `mem_*` outputs and all `p*_ready_o`/`p*_dout_o` are 0.
- A requester dropping `valid` while granted is illegal. The grant persists until `mem_ready_i`, and the completion is discarded.
- `mem_ready_i` seen in IDLE is ignored.

## Timing
- Reset (async assert, sync deassert upstream): state = IDLE, `last_q` = 1, all outputs 0, counters 0.
- Arbitration latency: `mem_valid_o` rises 1 cycle after `pn_valid_i` when the arbiter is IDLE.
- Completion: `pn_ready_o` is in the same cycle as `mem_ready_i` (zero-latency passthrough).
- One mandatory IDLE bubble after every completion. Back-to-back requests from the same port therefore take at least 2 cycles plus the memory latency.
- Fairness under continuous contention with PRIO_MODE=0: grants strictly alternate 0,1,0,1.
- Reset asserted mid-transaction: the grant is dropped immediately, `mem_valid_o` = 0, and no `ready` is issued.

## Configuration
- `CACHE_ARB_STATS_EN` defined:
  - `stat_grant0_o` / `stat_grant1_o` increment on each BUSY0 / BUSY1 completion.
  - `stat_wait_o` increments every cycle in which a `pn_valid_i` is high and port n is not in BUSYn.
  - All counters wrap modulo 2^32.
- Not defined: the stat ports remain present and are tied to 0; no counter flops are synthesized.

## Structure
- Package `cache_arb_pkg`:
  - state enum `arb_state_t` {IDLE, BUSY0, BUSY1}.
  - constants `ARB_PORT_I` = 0 and `ARB_PORT_D` = 1.
  - `PRIO_RR` = 0 and `PRIO_FIXED` = 1.
- One sub-module, `cache_arb_stats`, holding the three counters. It is instantiated only under `CACHE_ARB_STATS_EN`.

## Test plan
- Single port 0 read to 0x0000_1000, `mem_ready_i` 3 cycles after `mem_valid_o` → `mem_addr_o` = 0x1000, `mem_wmask_o` = 0, `p0_ready_o` is one pulse carrying `mem_dout_i` = 0xDEAD_BEEF, and `p1_ready_o` stays 0.
- Both ports valid from reset, PRIO_MODE=0, both held continuously for 4 transactions → grant order 0,1,0,1 with one IDLE cycle between each.
- PRIO_MODE=1, both held continuously → port 1 wins every arbitration and port 0 starves; `stat_wait_o` then counts every port-0 cycle.
- Port 1 write, `wmask` 0xF, `din` 0x1234_5678 at 0x2000, with port 0 asserting `valid` mid-transaction → write completes unaltered; port 0 is granted 2 cycles after `p1_ready_o`.
- `resetn` pulsed low during BUSY1 → `mem_valid_o` = 0 asynchronously, no `ready` pulse, state IDLE, and a subsequent tie is won by port 0.
- With `CACHE_ARB_STATS_EN`, 3 port-0 and 2 port-1 transactions → `stat_grant0_o` = 3 and `stat_grant1_o` = 2.
